// File: rtl/pong_ball.sv
// Per-frame ball physics for the pong top level.
// Moves the ball once per video frame (on the vsync leading edge), handling
// wall bounces, paddle bounces, misses with score pulses, and the
// hold-then-serve sequence after a point.
//
//   state | meaning
//   IDLE  | ball centred and frozen, waiting for a serve on a frame tick
//   PLAY  | ball advancing every frame tick
//   SCORE | ball frozen at its miss position for HOLD_FRAMES ticks
module pong_ball #(
  parameter int   H_ACTIVE    = 640,
  parameter int   V_ACTIVE    = 480,
  parameter int   BALL_SIZE   = 8,
  parameter int   SPEED_X     = 2,
  parameter int   SPEED_Y     = 2,
  parameter int   PAD_X_L     = 16,
  parameter int   PAD_X_R     = 616,
  parameter int   PAD_W       = 8,
  parameter int   PAD_H       = 64,
  parameter int   HOLD_FRAMES = 60,
  parameter logic VSYNC_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync,
  input  logic        serve,
  input  logic [10:0] lpad_y,
  input  logic [10:0] rpad_y,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic        in_play,
  output logic        l_point,
  output logic        r_point
);

  typedef enum logic [1:0] {IDLE, PLAY, SCORE} state_t;

  // 12-bit geometry so sums like pad_y + PAD_H never wrap
  localparam logic [11:0] X_MAX     = 12'(H_ACTIVE - BALL_SIZE);
  localparam logic [11:0] Y_MAX     = 12'(V_ACTIVE - BALL_SIZE);
  localparam logic [11:0] X_CTR     = 12'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [11:0] Y_CTR     = 12'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [11:0] SX        = 12'(SPEED_X);
  localparam logic [11:0] SY        = 12'(SPEED_Y);
  localparam logic [11:0] BS        = 12'(BALL_SIZE);
  localparam logic [11:0] PH        = 12'(PAD_H);
  localparam logic [11:0] R_FACE    = 12'(PAD_X_R);
  localparam logic [11:0] L_FACE    = 12'(PAD_X_L + PAD_W);
  localparam logic [11:0] X_HIT_R   = 12'(PAD_X_R - BALL_SIZE);
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_FRAMES - 1);

  state_t      state, state_d;
  logic [10:0] ball_x_d, ball_y_d;
  logic        dx, dx_d, dy, dy_d;   // 1 = increasing coordinate
  logic [7:0]  hold_cnt, hold_cnt_d;
  logic        l_point_d, r_point_d;
  logic        vs_q, tick;
  logic [11:0] bx, by, nx, ny, lp, rp;
  logic        ov_l, ov_r;

  // Free-running vsync history; a reset during active vsync must not fake a second tick
  always_ff @(posedge clk) begin
    vs_q <= vsync;
  end

  assign tick = (vsync == VSYNC_POL) && (vs_q != VSYNC_POL);

  assign bx   = {1'b0, ball_x};
  assign by   = {1'b0, ball_y};
  assign lp   = {1'b0, lpad_y};
  assign rp   = {1'b0, rpad_y};
  assign nx   = dx ? bx + SX : bx - SX;
  assign ny   = dy ? by + SY : by - SY;
  assign ov_l = (by + BS > lp) && (by < lp + PH);
  assign ov_r = (by + BS > rp) && (by < rp + PH);

  // Next-state and next-position logic, evaluated only on frame ticks
  always_comb begin
    state_d    = state;
    ball_x_d   = ball_x;
    ball_y_d   = ball_y;
    dx_d       = dx;
    dy_d       = dy;
    hold_cnt_d = hold_cnt;
    l_point_d  = 1'b0;
    r_point_d  = 1'b0;
    if (tick) begin
      unique case (state)
        IDLE: begin
          if (serve) state_d = PLAY;
        end
        PLAY: begin
          if (!dy && by < SY) begin
            ball_y_d = '0;
            dy_d     = 1'b1;
          end else if (dy && ny > Y_MAX) begin
            ball_y_d = Y_MAX[10:0];
            dy_d     = 1'b0;
          end else begin
            ball_y_d = ny[10:0];
          end
          if (dx) begin
            if (bx + BS <= R_FACE && nx + BS > R_FACE && ov_r) begin
              ball_x_d = X_HIT_R[10:0];
              dx_d     = 1'b0;
            end else if (nx > X_MAX) begin
              ball_x_d   = X_MAX[10:0];
              l_point_d  = 1'b1;
              state_d    = SCORE;
              hold_cnt_d = '0;
              dx_d       = 1'b1;   // next serve heads toward the right player, who conceded
            end else begin
              ball_x_d = nx[10:0];
            end
          end else begin
            if (bx >= L_FACE && nx < L_FACE && ov_l) begin
              ball_x_d = L_FACE[10:0];
              dx_d     = 1'b1;
            end else if (bx < SX) begin
              ball_x_d   = '0;
              r_point_d  = 1'b1;
              state_d    = SCORE;
              hold_cnt_d = '0;
              dx_d       = 1'b0;   // next serve heads toward the left player, who conceded
            end else begin
              ball_x_d = nx[10:0];
            end
          end
        end
        SCORE: begin
          if (hold_cnt == HOLD_LAST) begin
            state_d  = IDLE;
            ball_x_d = X_CTR[10:0];
            ball_y_d = Y_CTR[10:0];
          end else begin
            hold_cnt_d = hold_cnt + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers; reset overrides a coincident tick
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ball_x   <= X_CTR[10:0];
      ball_y   <= Y_CTR[10:0];
      dx       <= 1'b1;
      dy       <= 1'b1;
      hold_cnt <= '0;
      in_play  <= 1'b0;
      l_point  <= 1'b0;
      r_point  <= 1'b0;
    end else begin
      state    <= state_d;
      ball_x   <= ball_x_d;
      ball_y   <= ball_y_d;
      dx       <= dx_d;
      dy       <= dy_d;
      hold_cnt <= hold_cnt_d;
      in_play  <= (state_d == PLAY);
      l_point  <= l_point_d;
      r_point  <= r_point_d;
    end
  end

endmodule

// File: tb/tb_pong_ball.sv
// Bench for pong_ball: a frame-level physics model checked against the DUT
// every cycle, plus directed literal positions along a known trajectory.
module tb_pong_ball;

  localparam int X_MAX = 632;
  localparam int Y_MAX = 472;
  localparam int X_CTR = 316;
  localparam int Y_CTR = 236;
  localparam int M_IDLE = 0, M_PLAY = 1, M_SCORE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b1;
  logic        serve = 1'b0;
  logic [10:0] lpad_y = '0;
  logic [10:0] rpad_y = '0;
  logic [10:0] ball_x, ball_y;
  logic        in_play, l_point, r_point;

  pong_ball dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .serve(serve),
    .lpad_y(lpad_y), .rpad_y(rpad_y), .ball_x(ball_x), .ball_y(ball_y),
    .in_play(in_play), .l_point(l_point), .r_point(r_point)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state: position, unit directions, mode, ticks spent holding
  int   m_x = X_CTR, m_y = Y_CTR, m_dx = 1, m_dy = 1, m_mode = M_IDLE, m_held = 0;
  bit   m_lp = 0, m_rp = 0, m_valid = 0;
  logic m_vs_prev = 1'b1;

  function automatic bit overlaps(int by, int p);
    return (by + 8 > p) && (by < p + 64);
  endfunction

  // frame-level reference model, advanced at every clock edge
  always @(posedge clk) begin : model_p
    int nx, ny;
    bit t, ovl, ovr;
    t = (vsync == 1'b0) && (m_vs_prev != 1'b0);
    m_vs_prev = vsync;
    m_valid = 1;
    m_lp = 0;
    m_rp = 0;
    if (!rst_n) begin
      m_x = X_CTR; m_y = Y_CTR; m_dx = 1; m_dy = 1; m_mode = M_IDLE; m_held = 0;
    end else if (t) begin
      if (m_mode == M_IDLE) begin
        if (serve) m_mode = M_PLAY;
      end else if (m_mode == M_PLAY) begin
        nx  = m_x + 2 * m_dx;
        ny  = m_y + 2 * m_dy;
        ovl = overlaps(m_y, int'(lpad_y));
        ovr = overlaps(m_y, int'(rpad_y));
        if (ny < 0) begin m_y = 0; m_dy = 1; end
        else if (ny > Y_MAX) begin m_y = Y_MAX; m_dy = -1; end
        else m_y = ny;
        if (m_dx > 0) begin
          if (m_x + 8 <= 616 && nx + 8 > 616 && ovr) begin m_x = 608; m_dx = -1; end
          else if (nx > X_MAX) begin m_x = X_MAX; m_lp = 1; m_mode = M_SCORE; m_held = 0; end
          else m_x = nx;
        end else begin
          if (m_x >= 24 && nx < 24 && ovl) begin m_x = 24; m_dx = 1; end
          else if (nx < 0) begin m_x = 0; m_rp = 1; m_mode = M_SCORE; m_held = 0; end
          else m_x = nx;
        end
      end else begin
        m_held++;
        if (m_held == 60) begin m_mode = M_IDLE; m_x = X_CTR; m_y = Y_CTR; end
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (ball_x !== 11'(m_x) || ball_y !== 11'(m_y) || in_play !== (m_mode == M_PLAY) ||
          l_point !== m_lp || r_point !== m_rp) begin
        errors++;
        $display("FAIL model t=%0t got x=%0d y=%0d play=%0b lp=%0b rp=%0b required x=%0d y=%0d play=%0b lp=%0b rp=%0b",
                 $time, ball_x, ball_y, in_play, l_point, r_point,
                 m_x, m_y, m_mode == M_PLAY, m_lp, m_rp);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic chk_pos(input string name, input int ex, input int ey);
    chk({name, "_x"}, int'(ball_x), ex);
    chk({name, "_y"}, int'(ball_y), ey);
    chk({name, "_model_x"}, m_x, ex);
    chk({name, "_model_y"}, m_y, ey);
  endtask

  // returns at the negedge right after the tick edge
  task automatic tick_only();
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
  endtask

  task automatic finish_frame();
    repeat ($urandom_range(0, 2)) @(negedge clk);
    vsync = 1'b1;
    repeat ($urandom_range(1, 4)) @(negedge clk);
  endtask

  task automatic frame();
    tick_only();
    finish_frame();
  endtask

  int tk;
  task automatic run_to(input int n);
    while (tk < n) begin
      frame();
      tk++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int p;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_pos("reset", X_CTR, Y_CTR);
    chk("reset_in_play", int'(in_play), 0);

    repeat (3) frame();
    chk_pos("idle", X_CTR, Y_CTR);
    chk("idle_in_play", int'(in_play), 0);
    chk("idle_l_point", int'(l_point), 0);

    serve = 1'b1;
    tick_only();
    serve = 1'b0;
    tk = 0;
    chk("serve_in_play", int'(in_play), 1);
    chk_pos("serve", X_CTR, Y_CTR);
    finish_frame();

    rpad_y = 11'd400;
    lpad_y = 11'd0;
    run_to(1);   chk_pos("t1", 318, 238);
    run_to(118); chk("t118_y", int'(ball_y), 472);
    run_to(119); chk("t119_y", int'(ball_y), 472);
    run_to(120); chk("t120_y", int'(ball_y), 470);
    run_to(146); chk_pos("t146", 608, 418);
    run_to(147); chk_pos("t147_hit", 608, 416);
    run_to(148); chk("t148_x", int'(ball_x), 606);

    // reset landing on a tick edge
    @(negedge clk);
    vsync = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_pos("rst_tick", X_CTR, Y_CTR);
    chk("rst_tick_in_play", int'(in_play), 0);
    chk("rst_tick_l_point", int'(l_point), 0);
    finish_frame();
    frame();
    chk_pos("rst_after", X_CTR, Y_CTR);

    // second rally: right paddle out of the way, ball misses on the right
    rpad_y = 11'd0;
    serve = 1'b1;
    tick_only();
    serve = 1'b0;
    tk = 0;
    finish_frame();
    run_to(158); chk_pos("t158", 632, 394);
    tick_only();
    chk("miss_l_point", int'(l_point), 1);
    chk("miss_r_point", int'(r_point), 0);
    chk("miss_in_play", int'(in_play), 0);
    chk_pos("miss", 632, 392);
    @(negedge clk);
    chk("miss_l_point_end", int'(l_point), 0);
    finish_frame();
    repeat (59) frame();
    chk_pos("hold59", 632, 392);
    chk("hold59_in_play", int'(in_play), 0);
    frame();
    chk_pos("recentred", X_CTR, Y_CTR);
    serve = 1'b1;
    frame();
    serve = 1'b0;
    frame();
    chk_pos("reserve", 318, 234);

    // randomized play: paddles mostly tracking the ball, occasional resets
    repeat (1500) begin
      if ($urandom_range(0, 199) == 0) begin
        @(negedge clk);
        if ($urandom_range(0, 1) == 1) vsync = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        finish_frame();
      end
      serve = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) != 0) begin
        p = m_y + 6 - int'($urandom_range(0, 76));
        if (p < 0) p = 0;
        lpad_y = 11'(p);
        p = m_y + 6 - int'($urandom_range(0, 76));
        if (p < 0) p = 0;
        rpad_y = 11'(p);
      end else begin
        lpad_y = 11'($urandom_range(0, 2047));
        rpad_y = 11'($urandom_range(0, 2047));
      end
      frame();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
